// File: rtl/fetch_pkg.sv
// Purpose: shared widths, FSM state encoding and queue entry layout for the fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    // One decoded-stage entry: the PC tag travels alongside its instruction word.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } inst_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Purpose: small synchronous FIFO used for PC tags and for queued instructions.
// Latency: a push is visible at the head one cycle later; head data is read combinationally.
// Backpressure: none internally; push when full (without a pop) and pop when empty are ignored.
//
// Ports:
//   clk, clr      clock and asynchronous active-low reset
//   clear         synchronous flush of all entries (wins over push/pop)
//   push_vld/dat  write an entry at the tail
//   pop_rdy       remove the head entry
//   head_dat      current head entry (undefined when count is 0)
//   count         number of valid entries, 0..DEPTH
module fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     clear,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_rdy,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop   = pop_rdy && (count != '0);
    // A pop in the same cycle makes room, so a full queue may still accept.
    assign do_push  = push_vld && ((count != FULL) || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed through count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Purpose: issues in-order instruction reads for current_pc, tags them, queues returned words for decode.
// Latency: response in cycle N is at the queue head in cycle N+1; first request one cycle after reset.
// Backpressure: requests stop while queued + outstanding reach DEPTH; imem_ready low holds the PC.
//
// Ports:
//   clk, clr                      clock, asynchronous active-low reset
//   current_pc / pc_advance       PC from the PC flop; pc_advance pulses on every accepted request
//   flush                         redirect: drop queued and in-flight instructions
//   imem_req/addr/ready           request channel to instruction memory
//   imem_rvalid/rdata             in-order response channel
//   inst_valid/inst/inst_pc/ready queue head towards decode (inst and inst_pc are 0 when not valid)
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [ADDR_W-1:0] current_pc,
    output logic              pc_advance,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   CREDIT  = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    fetch_state_t      state;
    fetch_state_t      state_nxt;

    logic [CW-1:0]     out_cnt;
    logic [CW-1:0]     q_cnt;
    logic [CW-1:0]     drop_cnt;
    logic [CW-1:0]     drop_nxt;
    logic [CW:0]       credit_used;

    logic              accept;
    logic              rsp_ok;
    logic              rsp_keep;
    logic              q_pop;
    logic [ADDR_W-1:0] tag_head;
    inst_entry_t       q_in;
    inst_entry_t       q_head;

    // ------------------------------------------------------------------
    // Issue side
    // ------------------------------------------------------------------
    // Credit uses registered counts only, so a pop this cycle frees a slot
    // next cycle. Dropped responses still in flight hold their credit.
    assign credit_used = {1'b0, q_cnt} + {1'b0, out_cnt};
    assign imem_req    = (state != IDLE) && !flush && (credit_used < CREDIT);
    assign accept      = imem_req && imem_ready;
    assign pc_advance  = accept;
    assign imem_addr   = current_pc;

    // ------------------------------------------------------------------
    // Response side
    // ------------------------------------------------------------------
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_ok   = imem_rvalid && (out_cnt != '0);
    // Responses owed to a previous redirect, or arriving in the redirect
    // cycle itself, are discarded instead of queued.
    assign rsp_keep = rsp_ok && (drop_cnt == '0) && !flush;

    assign q_in.pc   = tag_head;
    assign q_in.inst = imem_rdata;

    // ------------------------------------------------------------------
    // Decode side
    // ------------------------------------------------------------------
    assign inst_valid = (q_cnt != '0);
    // The queue is cleared on a redirect, so a pop in that cycle is moot.
    assign q_pop      = inst_valid && inst_ready && !flush;
    assign inst       = inst_valid ? q_head.inst : '0;
    assign inst_pc    = inst_valid ? q_head.pc   : '0;

    // ------------------------------------------------------------------
    // Tag FIFO: one entry per accepted request, popped by every legal
    // response (kept or dropped). Its occupancy is exactly the number of
    // outstanding requests, so it doubles as out_cnt. Only reset clears it.
    // ------------------------------------------------------------------
    fetch_queue #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .clr      (clr),
        .clear    (1'b0),
        .push_vld (accept),
        .push_dat (current_pc),
        .pop_rdy  (rsp_ok),
        .head_dat (tag_head),
        .count    (out_cnt)
    );

    // ------------------------------------------------------------------
    // Instruction queue: {pc, inst} entries waiting for decode.
    // ------------------------------------------------------------------
    fetch_queue #(
        .WIDTH ($bits(inst_entry_t)),
        .DEPTH (DEPTH)
    ) u_inst_queue (
        .clk      (clk),
        .clr      (clr),
        .clear    (flush),
        .push_vld (rsp_keep),
        .push_dat (q_in),
        .pop_rdy  (q_pop),
        .head_dat (q_head),
        .count    (q_cnt)
    );

    // ------------------------------------------------------------------
    // Drop counter: how many of the outstanding responses belong to the
    // wrong path. On a redirect every outstanding request is wrong-path,
    // minus the one (if any) being retired in that same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        drop_nxt = drop_cnt;
        if (flush) begin
            drop_nxt = out_cnt - CW'(rsp_ok);
        end else if (rsp_ok && (drop_cnt != '0)) begin
            drop_nxt = drop_cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            drop_cnt <= '0;
        end else begin
            drop_cnt <= drop_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM. IDLE holds off the first request for one cycle so the
    // PC flop shows its reset vector. FLUSH marks that wrong-path responses
    // are still pending; issue continues in both RUN and FLUSH.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                state_nxt = RUN;
            end
            RUN: begin
                // A redirect with nothing left in flight needs no drain phase.
                if (flush && (drop_nxt != '0)) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                // Leaves when the last wrong-path response retires; a fresh
                // redirect that leaves responses pending keeps us here.
                if (drop_nxt == '0) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Purpose: self-checking bench for inst_fetch: directed cycle table, streaming, async reset, random traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_inst_fetch;

    localparam int          DEPTH = 4;
    localparam logic [31:0] P     = 32'h0040_0000;
    localparam logic [31:0] T     = 32'h0040_0100;
    localparam logic [31:0] T2    = 32'h0040_0200;

    logic        clk;
    logic        clr;
    logic [31:0] current_pc;
    logic        pc_advance;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    inst_fetch #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .clr         (clr),
        .current_pc  (current_pc),
        .pc_advance  (pc_advance),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int dut_vld_cnt = 0;

    // Instruction word stored in the memory model at a given address.
    function automatic logic [31:0] mw(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed vectors: one record per cycle after reset release.
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] cpc;
        bit          rdy;
        bit          rv;
        logic [31:0] rd;
        bit          ir;
        bit          fl;
        bit          req;
        bit          adv;
        bit          iv;
        logic [31:0] ipc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [31:0] cpc, input int rdy, input int rv, input logic [31:0] rd,
                                input int ir, input int fl, input int req, input int adv, input int iv,
                                input logic [31:0] ipc);
        vec_t v;
        v.cpc = cpc;       v.rdy = (rdy != 0); v.rv  = (rv != 0);  v.rd  = rd;
        v.ir  = (ir != 0); v.fl  = (fl != 0);  v.req = (req != 0); v.adv = (adv != 0);
        v.iv  = (iv != 0); v.ipc = ipc;
        return v;
    endfunction

    task automatic apply_vec(input vec_t v);
        @(negedge clk);
        current_pc  = v.cpc;
        imem_ready  = v.rdy;
        imem_rvalid = v.rv;
        imem_rdata  = v.rd;
        inst_ready  = v.ir;
        flush       = v.fl;
        #1;
        chk1 ("req",        imem_req,   v.req);
        chk1 ("pc_advance", pc_advance, v.adv);
        chk32("imem_addr",  imem_addr,  v.cpc);
        chk1 ("inst_valid", inst_valid, v.iv);
        chk32("inst_pc",    inst_pc,    v.iv ? v.ipc : 32'h0);
        chk32("inst",       inst,       v.iv ? mw(v.ipc) : 32'h0);
        cyc++;
    endtask

    // ------------------------------------------------------------------
    // Reference model: outstanding requests as a queue of {pc, due, drop},
    // delivered-but-unconsumed PCs as a queue; flush empties the latter and
    // marks every outstanding request as wrong-path.
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] pc;
        int          due;
        bit          drop;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [31:0] exp_q[$];
    bit          running;
    logic [31:0] pc_reg;

    task automatic model_reset();
        mem_q.delete();
        exp_q.delete();
        running = 1'b0;
        pc_reg  = P;
    endtask

    task automatic do_reset();
        clr         = 1'b0;
        flush       = 1'b0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        inst_ready  = 1'b0;
        current_pc  = P;
        repeat (3) @(posedge clk);
        #1;
        chk1 ("rst_req",        imem_req,   1'b0);
        chk1 ("rst_pc_advance", pc_advance, 1'b0);
        chk1 ("rst_inst_valid", inst_valid, 1'b0);
        chk32("rst_inst",       inst,       32'h0);
        chk32("rst_inst_pc",    inst_pc,    32'h0);
        chk32("rst_imem_addr",  imem_addr,  P);
        #1 clr = 1'b1;
        cyc = 0;
        model_reset();
    endtask

    task automatic async_reset_check();
        @(negedge clk);
        #2 clr = 1'b0;
        #1;
        chk1 ("arst_inst_valid", inst_valid, 1'b0);
        chk1 ("arst_req",        imem_req,   1'b0);
        chk1 ("arst_pc_advance", pc_advance, 1'b0);
        chk32("arst_inst",       inst,       32'h0);
        chk32("arst_inst_pc",    inst_pc,    32'h0);
        do_reset();
    endtask

    task automatic model_cycle(input int p_rdy, input int p_ir, input int p_fl, input int p_rv, input int max_lat);
        bit    fl;
        bit    rdy;
        bit    ir;
        bit    rv;
        bit    exp_req;
        bit    had;
        mreq_t e;
        @(negedge clk);
        fl  = running && (int'($urandom_range(99)) < p_fl);
        rdy = (int'($urandom_range(99)) < p_rdy);
        ir  = (int'($urandom_range(99)) < p_ir);
        rv  = 1'b0;
        if (mem_q.size() > 0) begin
            rv = (mem_q[0].due <= cyc) && (int'($urandom_range(99)) < p_rv);
        end
        current_pc  = pc_reg;
        flush       = fl;
        imem_ready  = rdy;
        imem_rvalid = rv;
        imem_rdata  = $urandom;
        if (rv) begin
            imem_rdata = mw(mem_q[0].pc);
        end
        inst_ready  = ir;
        exp_req = running && !fl && ((exp_q.size() + mem_q.size()) < DEPTH);
        #1;
        chk1 ("m_req",        imem_req,   exp_req);
        chk1 ("m_pc_advance", pc_advance, exp_req && rdy);
        chk32("m_imem_addr",  imem_addr,  pc_reg);
        chk1 ("m_inst_valid", inst_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            chk32("m_inst_pc", inst_pc, exp_q[0]);
            chk32("m_inst",    inst,    mw(exp_q[0]));
        end else begin
            chk32("m_inst_pc", inst_pc, 32'h0);
            chk32("m_inst",    inst,    32'h0);
        end
        if (inst_valid === 1'b1) dut_vld_cnt++;

        // Advance the model across the coming clock edge.
        had = exp_q.size() > 0;
        if (fl) begin
            exp_q.delete();
            foreach (mem_q[k]) mem_q[k].drop = 1'b1;
        end else if (had && ir) begin
            void'(exp_q.pop_front());
        end
        if (rv) begin
            e = mem_q.pop_front();
            if (!e.drop) exp_q.push_back(e.pc);
        end
        if (exp_req && rdy) begin
            e.pc   = pc_reg;
            e.due  = cyc + 1 + int'($urandom_range(max_lat));
            e.drop = 1'b0;
            mem_q.push_back(e);
            pc_reg = pc_reg + 32'd4;
        end
        if (fl) pc_reg = $urandom & 32'hFFFF_FFFC;
        running = 1'b1;
        cyc++;
    endtask

    initial begin
        // cpc, rdy, rv, rd, ir, fl | req, adv, iv, ipc
        tbl.push_back(mk(P,          1, 0, 32'h0,          0, 0,  0, 0, 0, 32'h0));   // IDLE
        tbl.push_back(mk(P,          1, 0, 32'h0,          0, 0,  1, 1, 0, 32'h0));   // first request
        tbl.push_back(mk(P + 32'h4,  1, 1, mw(P),          0, 0,  1, 1, 0, 32'h0));
        tbl.push_back(mk(P + 32'h8,  1, 1, mw(P + 32'h4),  0, 0,  1, 1, 1, P));
        tbl.push_back(mk(P + 32'hC,  1, 1, mw(P + 32'h8),  0, 0,  1, 1, 1, P));
        tbl.push_back(mk(P + 32'h10, 1, 1, mw(P + 32'hC),  0, 0,  0, 0, 1, P));       // credit exhausted
        tbl.push_back(mk(P + 32'h10, 1, 0, 32'h0,          0, 0,  0, 0, 1, P));
        tbl.push_back(mk(P + 32'h10, 1, 0, 32'h0,          1, 0,  0, 0, 1, P));       // pop does not free credit yet
        tbl.push_back(mk(P + 32'h10, 1, 0, 32'h0,          1, 0,  1, 1, 1, P + 32'h4));
        tbl.push_back(mk(P + 32'h14, 1, 1, mw(P + 32'h10), 1, 0,  1, 1, 1, P + 32'h8));
        tbl.push_back(mk(P + 32'h18, 1, 0, 32'h0,          0, 0,  1, 1, 1, P + 32'hC)); // 2 queued, 2 outstanding
        tbl.push_back(mk(P + 32'h1C, 1, 1, mw(P + 32'h14), 1, 1,  0, 0, 1, P + 32'hC)); // flush + response
        tbl.push_back(mk(T,          1, 1, mw(P + 32'h18), 1, 0,  1, 1, 0, 32'h0));   // dropped response
        tbl.push_back(mk(T + 32'h4,  1, 1, mw(T),          1, 0,  1, 1, 0, 32'h0));
        tbl.push_back(mk(T + 32'h8,  0, 0, 32'h0,          1, 0,  1, 0, 1, T));       // stall 1
        tbl.push_back(mk(T + 32'h8,  0, 1, mw(T + 32'h4),  1, 0,  1, 0, 0, 32'h0));   // stall 2
        tbl.push_back(mk(T + 32'h8,  0, 0, 32'h0,          1, 0,  1, 0, 1, T + 32'h4)); // stall 3
        tbl.push_back(mk(T + 32'h8,  1, 0, 32'h0,          1, 0,  1, 1, 0, 32'h0));
        tbl.push_back(mk(T + 32'hC,  0, 1, mw(T + 32'h8),  1, 0,  1, 0, 0, 32'h0));
        tbl.push_back(mk(T + 32'hC,  0, 0, 32'h0,          1, 0,  1, 0, 1, T + 32'h8));
        tbl.push_back(mk(T + 32'hC,  0, 1, 32'hBAD0_BAD0,  1, 0,  1, 0, 0, 32'h0));   // stray response
        tbl.push_back(mk(T + 32'hC,  0, 0, 32'h0,          1, 0,  1, 0, 0, 32'h0));
        tbl.push_back(mk(T + 32'hC,  1, 0, 32'h0,          1, 1,  0, 0, 0, 32'h0));   // flush, nothing in flight
        tbl.push_back(mk(T2,         1, 0, 32'h0,          1, 0,  1, 1, 0, 32'h0));
        tbl.push_back(mk(T2 + 32'h4, 0, 1, mw(T2),         1, 0,  1, 0, 0, 32'h0));
        tbl.push_back(mk(T2 + 32'h4, 0, 0, 32'h0,          1, 0,  1, 0, 1, T2));      // not dropped
        tbl.push_back(mk(T2 + 32'h4, 0, 0, 32'h0,          1, 0,  1, 0, 0, 32'h0));

        do_reset();
        foreach (tbl[i]) apply_vec(tbl[i]);

        // Streaming with 1-cycle memory: valid from cycle 3 on, every cycle.
        do_reset();
        dut_vld_cnt = 0;
        for (int i = 0; i < 20; i++) model_cycle(100, 100, 0, 100, 0);
        chk32("stream_valid_cycles", dut_vld_cnt, 32'd17);

        // Reset asserted while instructions are queued and in flight.
        async_reset_check();

        // Randomized traffic in three flavours, with one mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) async_reset_check();
            if (i < 1000)      model_cycle(70, 60, 4, 70, 2);
            else if (i < 2000) model_cycle(90, 30, 2, 90, 0);
            else               model_cycle(50, 90, 8, 50, 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
